// File: rtl/freelist_ckpt.sv
// Physical-register free list with branch checkpoints for the rename stage.
// Grants up to ALLOC_WIDTH registers per cycle; snapshots and restores the availability mask.
`ifndef N
`define N 3
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

module freelist_ckpt #(
  parameter int ALLOC_WIDTH = `N,
  parameter int PR_COUNT    = `PHYS_REG_SZ_R10K,
  parameter int ARCH_COUNT  = `ARCH_REG_SZ,
  parameter int NUM_CKPT    = 4,
  localparam int CK_W  = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
  localparam int LN_W  = (ALLOC_WIDTH > 1) ? $clog2(ALLOC_WIDTH) : 1,
  localparam int CNT_W = $clog2(PR_COUNT + 1)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [ALLOC_WIDTH-1:0]                alloc_req,
  input  logic [PR_COUNT-1:0]                   free_mask,
  input  logic                                  ckpt_save,
  input  logic [CK_W-1:0]                       ckpt_save_id,
  input  logic [LN_W-1:0]                       ckpt_lane,
  input  logic                                  restore_valid,
  input  logic [CK_W-1:0]                       restore_id,
  output logic [ALLOC_WIDTH-1:0][PR_COUNT-1:0]  granted_regs,
  output logic [ALLOC_WIDTH-1:0]                grant_valid,
  output logic [CNT_W-1:0]                      free_count,
  output logic [PR_COUNT-1:0]                   avail_mask
);

  localparam logic [PR_COUNT-1:0] INIT_MASK = {{(PR_COUNT-ARCH_COUNT){1'b1}}, {ARCH_COUNT{1'b0}}};
  localparam logic [PR_COUNT-1:0] ONE       = PR_COUNT'(1);

  logic [PR_COUNT-1:0] avail;
  logic [PR_COUNT-1:0] avail_next;
  logic [PR_COUNT-1:0] ckpt [NUM_CKPT];
  logic [PR_COUNT-1:0] rem;
  logic [PR_COUNT-1:0] pick;
  logic [PR_COUNT-1:0] g_all;
  logic [PR_COUNT-1:0] g_lo;
  logic [CNT_W-1:0]    cnt_next;
  logic                save_en;

  // Each lane takes the lowest remaining free bit, then removes it from the pool.
  always_comb begin
    rem          = avail;
    pick         = '0;
    g_all        = '0;
    g_lo         = '0;
    granted_regs = '0;
    grant_valid  = '0;
    for (int l = 0; l < ALLOC_WIDTH; l++) begin
      pick = rem & (~rem + ONE);
      if (alloc_req[l] && !restore_valid && !reset) begin
        granted_regs[l] = pick;
        grant_valid[l]  = |pick;
        rem             = rem & ~pick;
        g_all           = g_all | pick;
        if (LN_W'(l) <= ckpt_lane) g_lo = g_lo | pick;
      end
    end
  end

  assign save_en = ckpt_save && !restore_valid;

  always_comb begin
    if (restore_valid) avail_next = ckpt[restore_id] | free_mask;
    else               avail_next = (avail & ~g_all) | free_mask;
    cnt_next = '0;
    for (int i = 0; i < PR_COUNT; i++) cnt_next = cnt_next + CNT_W'(avail_next[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      avail      <= INIT_MASK;
      free_count <= CNT_W'(PR_COUNT - ARCH_COUNT);
      for (int s = 0; s < NUM_CKPT; s++) ckpt[s] <= INIT_MASK;
    end else begin
      avail      <= avail_next;
      free_count <= cnt_next;
      // Slots not being overwritten absorb retire frees so they survive recovery.
      for (int s = 0; s < NUM_CKPT; s++) begin
        if (save_en && (ckpt_save_id == CK_W'(s))) ckpt[s] <= (avail & ~g_lo) | free_mask;
        else                                       ckpt[s] <= ckpt[s] | free_mask;
      end
    end
  end

  assign avail_mask = avail;

endmodule

// File: tb/tb_freelist_ckpt.sv
// Self-checking bench for freelist_ckpt: directed test-plan steps followed by a random phase
// compared against a bit-array reference model of the free list and its checkpoints.
module tb_freelist_ckpt;

  localparam int AW = 3;
  localparam int PR = 64;
  localparam logic [63:0] INIT = 64'hFFFF_FFFF_0000_0000;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [AW-1:0]         alloc_req;
  logic [PR-1:0]         free_mask;
  logic                  ckpt_save;
  logic [1:0]            ckpt_save_id;
  logic [1:0]            ckpt_lane;
  logic                  restore_valid;
  logic [1:0]            restore_id;
  logic [AW-1:0][PR-1:0] granted_regs;
  logic [AW-1:0]         grant_valid;
  logic [6:0]            free_count;
  logic [PR-1:0]         avail_mask;

  freelist_ckpt #(.ALLOC_WIDTH(AW), .PR_COUNT(PR), .ARCH_COUNT(32), .NUM_CKPT(4)) dut (
    .clock(clock), .reset(reset), .alloc_req(alloc_req), .free_mask(free_mask),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id), .ckpt_lane(ckpt_lane),
    .restore_valid(restore_valid), .restore_id(restore_id), .granted_regs(granted_regs),
    .grant_valid(grant_valid), .free_count(free_count), .avail_mask(avail_mask)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  bit   m_free [PR];
  bit   m_ck   [4][PR];
  logic [63:0] obs_g [AW];
  logic [2:0]  obs_v;

  function automatic logic [63:0] p(input int n);
    logic [63:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_mask();
    logic [63:0] v;
    for (int i = 0; i < PR; i++) v[i] = m_free[i];
    return v;
  endfunction

  // One clock cycle: drive, check grants mid-cycle, advance model, check state after the edge.
  task automatic do_cycle(input logic [2:0] req, input logic [63:0] fm, input logic sv,
                          input logic [1:0] sid, input logic [1:0] ln, input logic rv,
                          input logic [1:0] rid, input logic rst);
    int  exp_lane [AW];
    bit  taken [PR];
    bit  old_free [PR];
    bit  in_lo [PR];
    bit  in_all [PR];
    int  cnt;
    reset = rst; alloc_req = req; free_mask = fm; ckpt_save = sv; ckpt_save_id = sid;
    ckpt_lane = ln; restore_valid = rv; restore_id = rid;
    for (int i = 0; i < PR; i++) begin taken[i] = 0; in_lo[i] = 0; in_all[i] = 0; end
    for (int l = 0; l < AW; l++) begin
      exp_lane[l] = -1;
      if (!rst && !rv && req[l]) begin
        for (int i = 0; i < PR; i++) begin
          if (m_free[i] && !taken[i]) begin
            exp_lane[l] = i;
            taken[i] = 1;
            in_all[i] = 1;
            if (l <= int'(ln)) in_lo[i] = 1;
            break;
          end
        end
      end
    end
    @(negedge clock);
    for (int l = 0; l < AW; l++) begin
      obs_g[l] = granted_regs[l];
      obs_v[l] = grant_valid[l];
      check($sformatf("grant_lane%0d", l), granted_regs[l], (exp_lane[l] < 0) ? 64'd0 : p(exp_lane[l]));
      check($sformatf("valid_lane%0d", l), {63'd0, grant_valid[l]}, {63'd0, exp_lane[l] >= 0});
    end
    @(posedge clock);
    for (int i = 0; i < PR; i++) old_free[i] = m_free[i];
    if (rst) begin
      for (int i = 0; i < PR; i++) begin
        m_free[i] = (i >= 32);
        for (int s = 0; s < 4; s++) m_ck[s][i] = (i >= 32);
      end
    end else begin
      for (int i = 0; i < PR; i++)
        m_free[i] = rv ? (m_ck[rid][i] || fm[i]) : ((old_free[i] && !in_all[i]) || fm[i]);
      for (int s = 0; s < 4; s++)
        for (int i = 0; i < PR; i++)
          if (sv && !rv && s == int'(sid)) m_ck[s][i] = (old_free[i] && !in_lo[i]) || fm[i];
          else                             m_ck[s][i] = m_ck[s][i] || fm[i];
    end
    #1;
    cnt = 0;
    for (int i = 0; i < PR; i++) cnt += int'(m_free[i]);
    check("avail_mask", avail_mask, model_mask());
    check("free_count", {57'd0, free_count}, 64'(cnt));
  endtask

  task automatic idle_rst();
    do_cycle(3'b000, 64'd0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic alloc(input logic [2:0] req);
    do_cycle(req, 64'd0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; alloc_req = 0; free_mask = 0; ckpt_save = 0; ckpt_save_id = 0;
    ckpt_lane = 0; restore_valid = 0; restore_id = 0;
    for (int i = 0; i < PR; i++) m_free[i] = 0;
    for (int s = 0; s < 4; s++) for (int i = 0; i < PR; i++) m_ck[s][i] = 0;

    // Reset while requesting: no grants, initial mask.
    do_cycle(3'b111, 64'd0, 0, 0, 0, 0, 0, 1);
    check("rst_valid", {61'd0, obs_v}, 64'd0);
    check("rst_count", {57'd0, free_count}, 64'd32);
    check("rst_avail", avail_mask, INIT);

    // Full bundle after reset.
    alloc(3'b111);
    check("b_l0", obs_g[0], p(32));
    check("b_l1", obs_g[1], p(33));
    check("b_l2", obs_g[2], p(34));
    check("b_v", {61'd0, obs_v}, 64'd7);
    check("b_cnt", {57'd0, free_count}, 64'd29);

    // Sparse request.
    idle_rst();
    alloc(3'b101);
    check("s_l0", obs_g[0], p(32));
    check("s_l1", obs_g[1], 64'd0);
    check("s_l2", obs_g[2], p(33));
    check("s_v", {61'd0, obs_v}, 64'd5);

    // Drain to empty, then a free becomes grantable one cycle later.
    idle_rst();
    for (int k = 0; k < 10; k++) alloc(3'b111);
    check("d_cnt2", {57'd0, free_count}, 64'd2);
    alloc(3'b111);
    check("d_l0", obs_g[0], p(62));
    check("d_l1", obs_g[1], p(63));
    check("d_v", {61'd0, obs_v}, 64'd3);
    check("d_cnt0", {57'd0, free_count}, 64'd0);
    do_cycle(3'b111, p(5), 0, 0, 0, 0, 0, 0);
    check("e_v", {61'd0, obs_v}, 64'd0);
    alloc(3'b001);
    check("e_l0", obs_g[0], p(5));

    // Checkpoint mid-bundle then restore.
    idle_rst();
    do_cycle(3'b111, 64'd0, 1, 2, 0, 0, 0, 0);
    alloc(3'b111);
    check("c_l0", obs_g[0], p(35));
    do_cycle(3'b111, 64'd0, 0, 0, 0, 1, 2, 0);
    check("c_rv", {61'd0, obs_v}, 64'd0);
    check("c_avail", avail_mask, 64'hFFFF_FFFE_0000_0000);
    check("c_cnt", {57'd0, free_count}, 64'd31);
    alloc(3'b001);
    check("c_next", obs_g[0], p(33));

    // Free during a live checkpoint survives restore.
    idle_rst();
    do_cycle(3'b000, 64'd0, 1, 1, 0, 0, 0, 0);
    do_cycle(3'b000, p(7), 0, 0, 0, 0, 0, 0);
    do_cycle(3'b000, 64'd0, 0, 0, 0, 1, 1, 0);
    check("f_p7", {63'd0, avail_mask[7]}, 64'd1);

    // Save and restore same slot in one cycle: restore wins, slot untouched.
    idle_rst();
    do_cycle(3'b111, 64'd0, 1, 0, 2, 0, 0, 0);
    alloc(3'b111);
    do_cycle(3'b111, 64'd0, 1, 0, 0, 1, 0, 0);
    check("sr_cnt1", {57'd0, free_count}, 64'd29);
    alloc(3'b111);
    do_cycle(3'b000, 64'd0, 0, 0, 0, 1, 0, 0);
    check("sr_cnt2", {57'd0, free_count}, 64'd29);
    check("sr_avail", avail_mask, 64'hFFFF_FFF8_0000_0000);
    do_cycle(3'b111, 64'd0, 0, 0, 0, 1, 0, 1);
    check("sr_rst", {57'd0, free_count}, 64'd32);

    // Random phase.
    for (int k = 0; k < 600; k++) begin
      logic [63:0] fm;
      fm = '0;
      if ($urandom_range(0, 2) == 0) fm[$urandom_range(0, 63)] = 1'b1;
      if ($urandom_range(0, 24) == 0) fm = {$urandom, $urandom};
      do_cycle(3'($urandom_range(0, 7)), fm, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 2)), $urandom_range(0, 11) == 0, 2'($urandom_range(0, 3)),
               $urandom_range(0, 149) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/freelist_ckpt.md
# freelist_ckpt

Checkpointing physical-register free list for the R10K-style rename stage. Hands out up to ALLOC_WIDTH one-hot physical registers per cycle to dispatch and accepts bulk frees from retire. Snapshots its availability state at branch dispatch into NUM_CKPT checkpoint slots, and restores a slot in one cycle on misprediction. Sits between dispatch/rename, retire and the branch-recovery controller.

## Interface
- ALLOC_WIDTH, default `N: allocation lanes per cycle.
- PR_COUNT, default `PHYS_REG_SZ_R10K: number of physical registers.
- ARCH_COUNT, default `ARCH_REG_SZ: registers 0..ARCH_COUNT-1 are mapped (busy) at reset.
- NUM_CKPT, default 4: number of checkpoint slots.
- CK_W = max(1, $clog2(NUM_CKPT)); LN_W = max(1, $clog2(ALLOC_WIDTH)); CNT_W = $clog2(PR_COUNT+1). These are derived localparams.
- Clocking: one clock; reset is synchronous and active-high.
- clock  in  1  system clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- alloc_req  in  ALLOC_WIDTH  per-lane allocation request.
- free_mask  in  PR_COUNT  registers freed by retire this cycle.
- ckpt_save  in  1  take a snapshot this cycle.
- ckpt_save_id  in  CK_W  destination slot.
- ckpt_lane  in  LN_W  lane of the branch; grants in lanes 0..ckpt_lane are included in the snapshot.
- restore_valid  in  1  misprediction recovery this cycle.
- restore_id  in  CK_W  slot to restore.
- granted_regs  out  ALLOC_WIDTH x PR_COUNT  one-hot grant per lane, or zero.
- grant_valid  out  ALLOC_WIDTH  lane received a register.
- free_count  out  CNT_W  registered popcount of avail.
- avail_mask  out  PR_COUNT  current avail register (debug and assertions).

## Operation
- State:
  - avail[PR_COUNT], where 1 = free.
  - ckpt[NUM_CKPT][PR_COUNT].
- Grant logic (combinational, from registered avail):
  - Requesting lanes are served in ascending lane order.
  - Each served lane gets the lowest-index free register not already taken by a lower lane.
  - Non-requesting lanes consume nothing.
  - If k free registers remain, only the first k requesting lanes are granted. The rest get granted_regs = 0 and grant_valid = 0.
- Grants to different lanes are never the same register.
- G = OR of all lane grants; G_lo = OR of grants for lanes 0..ckpt_lane.
- Normal update: avail <= (avail & ~G) | free_mask.
- Save, when ckpt_save and not restore_valid: ckpt[ckpt_save_id] <= (avail & ~G_lo) | free_mask.
- Checkpoint maintenance: every cycle, every slot other than one being written this cycle ORs in free_mask. Retired frees stay valid across recovery.
- Restore, when restore_valid:
  - All grant_valid are forced to 0 and granted_regs to 0 that cycle.
  - avail <= ckpt[restore_id] | free_mask.
  - Any ckpt_save in the same cycle is ignored (restore wins).
- A free_mask bit for an already-free register is a no-op (OR semantics).
- A checkpoint save in the same cycle as frees includes those frees.
- free_count <= popcount of the next avail value.

## Timing
- Grants are combinational from state: request in cycle t produces a grant in cycle t, and avail is cleared at the end of cycle t.
- A register freed in cycle t is grantable in cycle t+1, never in t.
- free_count, and avail_mask, reflect state after edge t at cycle t+1.
- Restore at edge t: first grants from the restored state are in cycle t+1.
- Reset, synchronous, applied at any point including mid-restore:
  - avail = {ones for PR_COUNT-ARCH_COUNT, zeros for ARCH_COUNT}.
  - All ckpt slots = the same initial mask.
  - free_count = PR_COUNT-ARCH_COUNT.
  - While reset is high, grant_valid = 0 and granted_regs = 0.
- Empty: free_count = 0 gives all grant_valid = 0. Alloc requests are dropped, not queued; dispatch must stall.
- Full: all PR_COUNT registers free is legal. No wrap-around, because the state is mask-based.

## Test plan
All scenarios use PR_COUNT=64, ARCH_COUNT=32, ALLOC_WIDTH=3, NUM_CKPT=4.
- Reset then alloc_req=3'b111 -> lanes get P32, P33, P34 and grant_valid=3'b111. Next cycle free_count=29.
- alloc_req=3'b101 after reset -> lane0=P32, lane1=0, lane2=P33, grant_valid=3'b101.
- Drain to 2 free (P62, P63) then alloc_req=3'b111 -> lane0=P62, lane1=P63, lane2 not granted. Next cycle free_count=0. free_mask bit 5 in that cycle -> P5 granted to lane0 the following cycle.
- Checkpoint mid-bundle:
  - After reset, alloc_req=3'b111 with ckpt_save=1, id=2, ckpt_lane=0. Then allocate 3 more (P35..P37).
  - restore_valid, id=2 -> grants suppressed that cycle.
  - Next cycle avail has P33..P63 free, free_count=31, and the next grant is P33.
- Free during a live checkpoint: save slot 1, then free_mask bit 7 (P7), then restore slot 1 -> P7 is free after the restore.
- Save and restore in the same cycle to the same id -> the restore uses the old slot contents and the slot is unchanged. Reset asserted in the restore cycle -> initial state, free_count=32.
